// File: rtl/rv32_pipe_pkg.sv
// Shared types for the RV32 5-stage pipeline control slice:
// forwarding-select encodings and the data-memory wait FSM state.
package rv32_pipe_pkg;

   localparam logic [1:0] FWD_REG  = 2'd0;
   localparam logic [1:0] FWD_EXE  = 2'd1;
   localparam logic [1:0] FWD_MEM  = 2'd2;
   localparam logic [1:0] FWD_LOAD = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter (sat_counter): clk, rst (sync, active-high),
// inc (count this cycle) -> count (W bits, holds at all-ones).
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc && count != '1)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / forwarding / data-memory stall controller for the RV32 pipe.
// In: ID/EX/MEM register info, mem_ready. Out: stage enables, flushes,
// forward selects, mem_req, stall/flush performance counters.
module pipe_hazard_ctrl
   import rv32_pipe_pkg::*;
#(
   parameter int FWD_EN = 1,
   parameter int RA_W   = 5,
   parameter int CNT_W  = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rs1use_id,
   input  logic            rs2use_id,
   input  logic [RA_W-1:0] rs1_id,
   input  logic [RA_W-1:0] rs2_id,
   input  logic            store_id,
   input  logic            branch_id,
   input  logic            regwrite_exe,
   input  logic            load_exe,
   input  logic [RA_W-1:0] rd_exe,
   input  logic [RA_W-1:0] rs2_exe,
   input  logic            store_exe,
   input  logic            regwrite_mem,
   input  logic            load_mem,
   input  logic            memacc_mem,
   input  logic [RA_W-1:0] rd_mem,
   input  logic            mem_ready,
   output logic            mem_req,
   output logic            pc_en_if,
   output logic            fd_en,
   output logic            de_en,
   output logic            em_en,
   output logic            mw_en,
   output logic            fd_flush,
   output logic            de_flush,
   output logic            em_flush,
   output logic            mw_flush,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b,
   output logic            fwd_ls,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam bit FWD = (FWD_EN != 0);

   mem_state_t state;

   logic ex_ok, mm_ok;
   logic ex1, ex2, mm1, mm2;
   logic lu, dstall, req, freeze;
   logic ds_act, br_act;

   function automatic logic [1:0] sel(
      input logic e,
      input logic m,
      input logic ld
   );
      if (e)
         return FWD_EXE;
      if (m)
         return ld ? FWD_LOAD : FWD_MEM;
      return FWD_REG;
   endfunction

   assign ex_ok = regwrite_exe && rd_exe != '0;
   assign mm_ok = regwrite_mem && rd_mem != '0;
   assign ex1   = ex_ok && rs1use_id && rd_exe == rs1_id;
   assign ex2   = ex_ok && rs2use_id && rd_exe == rs2_id;
   assign mm1   = mm_ok && rs1use_id && rd_mem == rs1_id;
   assign mm2   = mm_ok && rs2use_id && rd_mem == rs2_id;

   // A store only needing the load result as store data does not stall:
   // it is picked up later from MEM through fwd_ls.
   assign lu = load_exe && (ex1 || ex2)
            && !(store_id && ex2 && !ex1);

   assign dstall = FWD ? lu : (ex1 || ex2 || mm1 || mm2);

   // The access cycle itself freezes too, so N wait cycles cost N bubbles.
   assign req    = memacc_mem || state == WAIT;
   assign freeze = req && !mem_ready;

   assign ds_act = dstall && !freeze;
   assign br_act = branch_id && !freeze && !dstall;

   always_comb begin
      mem_req  = 1'b0;
      pc_en_if = 1'b1;
      fd_en    = 1'b1;
      de_en    = 1'b1;
      em_en    = 1'b1;
      mw_en    = 1'b1;
      fd_flush = 1'b0;
      de_flush = 1'b0;
      em_flush = 1'b0;
      mw_flush = 1'b0;
      fwd_a    = FWD_REG;
      fwd_b    = FWD_REG;
      fwd_ls   = 1'b0;
      if (!rst) begin
         mem_req = req;
         if (FWD) begin
            fwd_a  = sel(ex1, mm1, load_mem);
            fwd_b  = sel(ex2, mm2, load_mem);
            fwd_ls = store_exe && load_mem && mm_ok
                  && rd_mem == rs2_exe;
         end
         unique case (1'b1)
            freeze: begin
               pc_en_if = 1'b0;
               fd_en    = 1'b0;
               de_en    = 1'b0;
               em_en    = 1'b0;
               mw_flush = 1'b1;
            end
            ds_act: begin
               pc_en_if = 1'b0;
               fd_en    = 1'b0;
               de_flush = 1'b1;
            end
            br_act: fd_flush = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         unique case (state)
            IDLE: if (memacc_mem && !mem_ready) state <= WAIT;
            WAIT: if (mem_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
   end

   sat_counter #(.W(CNT_W)) u_stall (
      .clk   (clk),
      .rst   (rst),
      .inc   (!pc_en_if),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush (
      .clk   (clk),
      .rst   (rst),
      .inc   (fd_flush),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: full-forwarding instance and a
// stall-only, 2-bit-counter instance driven from one stimulus.
module tb_pipe_hazard_ctrl;

   localparam logic [9:0] NRM = 10'b0_11111_0000;
   localparam logic [9:0] STL = 10'b0_00111_0100;
   localparam logic [9:0] FRZ = 10'b1_00001_0001;
   localparam logic [9:0] BRF = 10'b0_11111_1000;
   localparam logic [9:0] REQ = 10'b1_00000_0000;

   typedef struct packed {
      logic       rst;
      logic       r1u, r2u;
      logic [4:0] r1, r2;
      logic       st_id, br_id;
      logic       rw_e, ld_e;
      logic [4:0] rd_e, rs2_e;
      logic       st_e;
      logic       rw_m, ld_m, ma_m;
      logic [4:0] rd_m;
      logic       rdy;
   } stim_t;

   typedef struct {
      string       nm;
      int          idx;
      logic [14:0] c;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic rs1use_id, rs2use_id, store_id, branch_id;
   logic [4:0] rs1_id, rs2_id, rd_exe, rs2_exe, rd_mem;
   logic regwrite_exe, load_exe, store_exe;
   logic regwrite_mem, load_mem, memacc_mem, mem_ready;

   logic mem_req0, pc0, fd0, de0, em0, mw0;
   logic fdf0, def0, emf0, mwf0, ls0;
   logic [1:0] fa0, fb0;
   logic [15:0] sc0, fc0;
   logic mem_req1, pc1, fd1, de1, em1, mw1;
   logic fdf1, def1, emf1, mwf1, ls1;
   logic [1:0] fa1, fb1;
   logic [1:0] sc1, fc1;

   logic [14:0] c0, c1;
   assign c0 = {mem_req0, pc0, fd0, de0, em0, mw0,
                fdf0, def0, emf0, mwf0, fa0, fb0, ls0};
   assign c1 = {mem_req1, pc1, fd1, de1, em1, mw1,
                fdf1, def1, emf1, mwf1, fa1, fb1, ls1};

   exp_t sb[$];
   int ncmp = 0;
   int nerr = 0;
   int exp_sc = 0;
   int exp_fc = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl u0 (
      .clk(clk), .rst(rst),
      .rs1use_id(rs1use_id), .rs2use_id(rs2use_id),
      .rs1_id(rs1_id), .rs2_id(rs2_id),
      .store_id(store_id), .branch_id(branch_id),
      .regwrite_exe(regwrite_exe), .load_exe(load_exe),
      .rd_exe(rd_exe), .rs2_exe(rs2_exe), .store_exe(store_exe),
      .regwrite_mem(regwrite_mem), .load_mem(load_mem),
      .memacc_mem(memacc_mem), .rd_mem(rd_mem),
      .mem_ready(mem_ready), .mem_req(mem_req0),
      .pc_en_if(pc0), .fd_en(fd0), .de_en(de0), .em_en(em0),
      .mw_en(mw0), .fd_flush(fdf0), .de_flush(def0),
      .em_flush(emf0), .mw_flush(mwf0),
      .fwd_a(fa0), .fwd_b(fb0), .fwd_ls(ls0),
      .stall_cnt(sc0), .flush_cnt(fc0)
   );

   pipe_hazard_ctrl #(.FWD_EN(0), .RA_W(5), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst),
      .rs1use_id(rs1use_id), .rs2use_id(rs2use_id),
      .rs1_id(rs1_id), .rs2_id(rs2_id),
      .store_id(store_id), .branch_id(branch_id),
      .regwrite_exe(regwrite_exe), .load_exe(load_exe),
      .rd_exe(rd_exe), .rs2_exe(rs2_exe), .store_exe(store_exe),
      .regwrite_mem(regwrite_mem), .load_mem(load_mem),
      .memacc_mem(memacc_mem), .rd_mem(rd_mem),
      .mem_ready(mem_ready), .mem_req(mem_req1),
      .pc_en_if(pc1), .fd_en(fd1), .de_en(de1), .em_en(em1),
      .mw_en(mw1), .fd_flush(fdf1), .de_flush(def1),
      .em_flush(emf1), .mw_flush(mwf1),
      .fwd_a(fa1), .fwd_b(fb1), .fwd_ls(ls1),
      .stall_cnt(sc1), .flush_cnt(fc1)
   );

   function automatic logic [14:0] ev(
      input logic [9:0] m, input logic [1:0] a,
      input logic [1:0] b, input logic l);
      return {m, a, b, l};
   endfunction

   function automatic stim_t nop();
      stim_t s;
      s = '0;
      return s;
   endfunction

   // lw x5 in EX, reader of x5 as rs1 in ID
   function automatic stim_t lu_in(input stim_t b);
      stim_t s;
      s = b;
      s.ld_e = 1'b1; s.rw_e = 1'b1; s.rd_e = 5'd5;
      s.r1u = 1'b1; s.r1 = 5'd5;
      return s;
   endfunction

   function automatic stim_t ma_in(input stim_t b, input logic rdy);
      stim_t s;
      s = b;
      s.ma_m = 1'b1; s.rdy = rdy;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      rst = s.rst;
      rs1use_id = s.r1u; rs2use_id = s.r2u;
      rs1_id = s.r1; rs2_id = s.r2;
      store_id = s.st_id; branch_id = s.br_id;
      regwrite_exe = s.rw_e; load_exe = s.ld_e;
      rd_exe = s.rd_e; rs2_exe = s.rs2_e; store_exe = s.st_e;
      regwrite_mem = s.rw_m; load_mem = s.ld_m;
      memacc_mem = s.ma_m; rd_mem = s.rd_m; mem_ready = s.rdy;
   endtask

   task automatic test_reset();
      stim_t s[2];
      logic [14:0] e[2];
      exp_t x;
      s[0] = ma_in(lu_in(nop()), 1'b0);
      s[0].rst = 1'b1; s[0].br_id = 1'b1;
      s[0].st_e = 1'b1; s[0].rs2_e = 5'd5;
      s[0].rw_m = 1'b1; s[0].ld_m = 1'b1; s[0].rd_m = 5'd5;
      e[0] = ev(NRM, 2'd0, 2'd0, 1'b0);
      s[1] = nop();
      e[1] = ev(NRM, 2'd0, 2'd0, 1'b0);
      foreach (s[i]) begin
         apply(s[i]);
         sb.push_back('{"reset", i, e[i]});
         @(negedge clk);
         x = sb.pop_front();
         ncmp++;
         if (c0 !== x.c) begin
            nerr++;
            $display("FAIL %s[%0d] ctl got %h want %h",
                     x.nm, x.idx, c0, x.c);
         end
         if (s[i].rst) begin exp_sc = 0; exp_fc = 0; end
         @(posedge clk); #1;
      end
      ncmp++;
      if (sc0 !== 16'd0 || fc0 !== 16'd0 || sc1 !== 2'd0) begin
         nerr++;
         $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0",
                  sc0, fc0, sc1);
      end
   endtask

   task automatic test_load_use();
      stim_t s[3];
      logic [14:0] e[3];
      exp_t x;
      s[0] = lu_in(nop()); s[0].r2u = 1'b1; s[0].r2 = 5'd1;
      e[0] = ev(STL, 2'd1, 2'd0, 1'b0);
      s[1] = nop(); s[1].r1u = 1'b1; s[1].r1 = 5'd5;
      s[1].r2u = 1'b1; s[1].r2 = 5'd1;
      s[1].rw_m = 1'b1; s[1].ld_m = 1'b1; s[1].rd_m = 5'd5;
      e[1] = ev(NRM, 2'd3, 2'd0, 1'b0);
      s[2] = nop();
      e[2] = ev(NRM, 2'd0, 2'd0, 1'b0);
      foreach (s[i]) begin
         apply(s[i]);
         sb.push_back('{"load_use", i, e[i]});
         @(negedge clk);
         x = sb.pop_front();
         ncmp++;
         if (c0 !== x.c) begin
            nerr++;
            $display("FAIL %s[%0d] ctl got %h want %h",
                     x.nm, x.idx, c0, x.c);
         end
         if (!x.c[13]) exp_sc++;
         if (x.c[8]) exp_fc++;
         @(posedge clk); #1;
      end
      ncmp++;
      if (sc0 !== 16'(exp_sc)) begin
         nerr++;
         $display("FAIL load_use_cnt got %0d want %0d", sc0, exp_sc);
      end
   endtask

   task automatic test_alu_chain();
      stim_t s[5];
      logic [14:0] e[5];
      exp_t x;
      foreach (s[i]) begin
         s[i] = nop();
         s[i].r1u = 1'b1; s[i].r2u = 1'b1;
         s[i].r1 = 5'd5; s[i].r2 = 5'd5;
      end
      s[0].rw_e = 1'b1; s[0].rd_e = 5'd5;
      e[0] = ev(NRM, 2'd1, 2'd1, 1'b0);
      s[1].rw_m = 1'b1; s[1].rd_m = 5'd5;
      e[1] = ev(NRM, 2'd2, 2'd2, 1'b0);
      s[2].rw_e = 1'b1; s[2].rd_e = 5'd5;
      s[2].rw_m = 1'b1; s[2].rd_m = 5'd5; s[2].ld_m = 1'b1;
      e[2] = ev(NRM, 2'd1, 2'd1, 1'b0);
      s[3].rw_e = 1'b1; s[3].rd_e = 5'd0;
      s[3].r1 = 5'd0; s[3].r2 = 5'd0;
      e[3] = ev(NRM, 2'd0, 2'd0, 1'b0);
      s[4].rw_e = 1'b1; s[4].rd_e = 5'd5; s[4].r1u = 1'b0;
      e[4] = ev(NRM, 2'd0, 2'd1, 1'b0);
      foreach (s[i]) begin
         apply(s[i]);
         sb.push_back('{"alu_chain", i, e[i]});
         @(negedge clk);
         x = sb.pop_front();
         ncmp++;
         if (c0 !== x.c) begin
            nerr++;
            $display("FAIL %s[%0d] ctl got %h want %h",
                     x.nm, x.idx, c0, x.c);
         end
         if (!x.c[13]) exp_sc++;
         if (x.c[8]) exp_fc++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store_load();
      stim_t s[4];
      logic [14:0] e[4];
      exp_t x;
      s[0] = nop(); s[0].st_id = 1'b1;
      s[0].r1u = 1'b1; s[0].r1 = 5'd2;
      s[0].r2u = 1'b1; s[0].r2 = 5'd5;
      s[0].ld_e = 1'b1; s[0].rw_e = 1'b1; s[0].rd_e = 5'd5;
      e[0] = ev(NRM, 2'd0, 2'd1, 1'b0);
      s[1] = nop(); s[1].st_e = 1'b1; s[1].rs2_e = 5'd5;
      s[1].ld_m = 1'b1; s[1].rw_m = 1'b1; s[1].rd_m = 5'd5;
      e[1] = ev(NRM, 2'd0, 2'd0, 1'b1);
      s[2] = s[1]; s[2].rs2_e = 5'd0; s[2].rd_m = 5'd0;
      e[2] = ev(NRM, 2'd0, 2'd0, 1'b0);
      s[3] = s[0]; s[3].r1 = 5'd5;
      e[3] = ev(STL, 2'd1, 2'd1, 1'b0);
      foreach (s[i]) begin
         apply(s[i]);
         sb.push_back('{"store_load", i, e[i]});
         @(negedge clk);
         x = sb.pop_front();
         ncmp++;
         if (c0 !== x.c) begin
            nerr++;
            $display("FAIL %s[%0d] ctl got %h want %h",
                     x.nm, x.idx, c0, x.c);
         end
         if (!x.c[13]) exp_sc++;
         if (x.c[8]) exp_fc++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      stim_t s[6];
      logic [14:0] e[6];
      exp_t x;
      s[0] = nop(); s[0].br_id = 1'b1;
      e[0] = ev(BRF, 2'd0, 2'd0, 1'b0);
      s[1] = nop();
      e[1] = ev(NRM, 2'd0, 2'd0, 1'b0);
      s[2] = lu_in(nop()); s[2].br_id = 1'b1;
      e[2] = ev(STL, 2'd1, 2'd0, 1'b0);
      s[3] = ma_in(nop(), 1'b0); s[3].br_id = 1'b1;
      e[3] = ev(FRZ, 2'd0, 2'd0, 1'b0);
      s[4] = ma_in(nop(), 1'b1); s[4].br_id = 1'b1;
      e[4] = ev(BRF | REQ, 2'd0, 2'd0, 1'b0);
      s[5] = nop();
      e[5] = ev(NRM, 2'd0, 2'd0, 1'b0);
      foreach (s[i]) begin
         apply(s[i]);
         sb.push_back('{"branch", i, e[i]});
         @(negedge clk);
         x = sb.pop_front();
         ncmp++;
         if (c0 !== x.c) begin
            nerr++;
            $display("FAIL %s[%0d] ctl got %h want %h",
                     x.nm, x.idx, c0, x.c);
         end
         if (i == 1) begin
            ncmp++;
            if (fc0 !== 16'd1) begin
               nerr++;
               $display("FAIL branch_fcnt got %0d want 1", fc0);
            end
         end
         if (!x.c[13]) exp_sc++;
         if (x.c[8]) exp_fc++;
         @(posedge clk); #1;
      end
      ncmp++;
      if (fc0 !== 16'(exp_fc) || sc0 !== 16'(exp_sc)) begin
         nerr++;
         $display("FAIL branch_cnt got %0d/%0d want %0d/%0d",
                  sc0, fc0, exp_sc, exp_fc);
      end
   endtask

   task automatic test_mem_wait();
      stim_t s[9];
      logic [14:0] e[9];
      int base;
      exp_t x;
      base = exp_sc;
      for (int i = 0; i < 3; i++) begin
         s[i] = ma_in(nop(), 1'b0);
         e[i] = ev(FRZ, 2'd0, 2'd0, 1'b0);
      end
      s[3] = ma_in(nop(), 1'b1);
      e[3] = ev(NRM | REQ, 2'd0, 2'd0, 1'b0);
      s[4] = nop();
      e[4] = ev(NRM, 2'd0, 2'd0, 1'b0);
      s[5] = ma_in(nop(), 1'b1);
      e[5] = ev(NRM | REQ, 2'd0, 2'd0, 1'b0);
      s[6] = ma_in(lu_in(nop()), 1'b0);
      e[6] = ev(FRZ, 2'd1, 2'd0, 1'b0);
      s[7] = ma_in(lu_in(nop()), 1'b1);
      e[7] = ev(STL | REQ, 2'd1, 2'd0, 1'b0);
      s[8] = nop();
      e[8] = ev(NRM, 2'd0, 2'd0, 1'b0);
      foreach (s[i]) begin
         apply(s[i]);
         sb.push_back('{"mem_wait", i, e[i]});
         @(negedge clk);
         x = sb.pop_front();
         ncmp++;
         if (c0 !== x.c) begin
            nerr++;
            $display("FAIL %s[%0d] ctl got %h want %h",
                     x.nm, x.idx, c0, x.c);
         end
         if (i == 4) begin
            ncmp++;
            if (sc0 !== 16'(base + 3)) begin
               nerr++;
               $display("FAIL mem_wait_scnt got %0d want %0d",
                        sc0, base + 3);
            end
         end
         if (!x.c[13]) exp_sc++;
         if (x.c[8]) exp_fc++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_nofwd();
      stim_t s[9];
      logic [14:0] e[9];
      exp_t x;
      s[0] = nop(); s[0].rst = 1'b1;
      e[0] = ev(NRM, 2'd0, 2'd0, 1'b0);
      s[1] = nop(); s[1].r1u = 1'b1; s[1].r1 = 5'd5;
      s[1].rw_e = 1'b1; s[1].rd_e = 5'd5;
      e[1] = ev(STL, 2'd0, 2'd0, 1'b0);
      s[2] = nop(); s[2].r1u = 1'b1; s[2].r1 = 5'd5;
      s[2].rw_m = 1'b1; s[2].rd_m = 5'd5;
      e[2] = ev(STL, 2'd0, 2'd0, 1'b0);
      s[3] = nop(); s[3].r1u = 1'b1; s[3].r1 = 5'd5;
      e[3] = ev(NRM, 2'd0, 2'd0, 1'b0);
      s[4] = nop(); s[4].st_e = 1'b1; s[4].rs2_e = 5'd5;
      s[4].ld_m = 1'b1; s[4].rw_m = 1'b1; s[4].rd_m = 5'd5;
      e[4] = ev(NRM, 2'd0, 2'd0, 1'b0);
      for (int i = 5; i < 8; i++) begin
         s[i] = nop(); s[i].r2u = 1'b1; s[i].r2 = 5'd5;
         s[i].rw_e = 1'b1; s[i].rd_e = 5'd5;
         e[i] = ev(STL, 2'd0, 2'd0, 1'b0);
      end
      s[8] = nop();
      e[8] = ev(NRM, 2'd0, 2'd0, 1'b0);
      foreach (s[i]) begin
         apply(s[i]);
         sb.push_back('{"nofwd", i, e[i]});
         @(negedge clk);
         x = sb.pop_front();
         ncmp++;
         if (c1 !== x.c) begin
            nerr++;
            $display("FAIL %s[%0d] ctl got %h want %h",
                     x.nm, x.idx, c1, x.c);
         end
         if (i == 3) begin
            ncmp++;
            if (sc1 !== 2'd2) begin
               nerr++;
               $display("FAIL nofwd_scnt got %0d want 2", sc1);
            end
         end
         @(posedge clk); #1;
      end
      ncmp++;
      if (sc1 !== 2'd3) begin
         nerr++;
         $display("FAIL nofwd_sat got %0d want 3", sc1);
      end
   endtask

   task automatic test_rst_wait();
      stim_t s[4];
      logic [14:0] e[4];
      exp_t x;
      s[0] = ma_in(nop(), 1'b0);
      e[0] = ev(FRZ, 2'd0, 2'd0, 1'b0);
      s[1] = ma_in(nop(), 1'b0);
      e[1] = ev(FRZ, 2'd0, 2'd0, 1'b0);
      s[2] = ma_in(nop(), 1'b0); s[2].rst = 1'b1;
      e[2] = ev(NRM, 2'd0, 2'd0, 1'b0);
      s[3] = nop();
      e[3] = ev(NRM, 2'd0, 2'd0, 1'b0);
      foreach (s[i]) begin
         apply(s[i]);
         sb.push_back('{"rst_wait", i, e[i]});
         @(negedge clk);
         x = sb.pop_front();
         ncmp++;
         if (c0 !== x.c) begin
            nerr++;
            $display("FAIL %s[%0d] ctl got %h want %h",
                     x.nm, x.idx, c0, x.c);
         end
         @(posedge clk); #1;
      end
      ncmp++;
      if (sc0 !== 16'd0 || fc0 !== 16'd0 || sc1 !== 2'd0) begin
         nerr++;
         $display("FAIL rst_wait_cnt got %0d/%0d/%0d want 0/0/0",
                  sc0, fc0, sc1);
      end
   endtask

   initial begin
      stim_t s;
      s = nop();
      s.rst = 1'b1;
      apply(s);
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_alu_chain();
      test_store_load();
      test_branch();
      test_mem_wait();
      test_nofwd();
      test_rst_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nerr);
      $finish;
   end

endmodule
